// File: rtl/e1_rr_sched_if.sv
// Channel-side inputs and shared output bus of the E1 round-robin scheduler.
// master drives channel bytes and downstream ready; slave is the scheduler.
interface e1_rr_sched_if #(
  parameter int unsigned WID    = 8,
  parameter int unsigned NCH    = 21,
  parameter int unsigned CHNBIT = 5
);
  logic [NCH*WID-1:0] di;
  logic [NCH-1:0]     vld;
  logic [NCH-1:0]     chen;
  logic               ovfclr;
  logic [CHNBIT-1:0]  oid;
  logic [WID-1:0]     dout;
  logic               dovld;
  logic               dordy;
  logic [NCH-1:0]     pend;
  logic [NCH-1:0]     ovf;

  modport master (
    output di, vld, chen, ovfclr, dordy,
    input  oid, dout, dovld, pend, ovf
  );

  modport slave (
    input  di, vld, chen, ovfclr, dordy,
    output oid, dout, dovld, pend, ovf
  );
endinterface

// File: rtl/e1_rr_sched.sv
// Work-conserving round-robin scheduler: one holding byte per E1 channel,
// one grant per cycle onto a shared valid/ready byte bus tagged with channel ID.
module e1_rr_sched #(
  parameter int unsigned WID    = 8,
  parameter int unsigned NCH    = 21,
  parameter int unsigned CHNBIT = 5
) (
  input  logic           clk,
  input  logic           rst,
  e1_rr_sched_if.slave   bus
);

  localparam int unsigned SW = CHNBIT + 1;

  logic [NCH-1:0][WID-1:0] hold_q, hold_d;
  logic [NCH-1:0]          pend_q, pend_d;
  logic [NCH-1:0]          ovf_q, ovf_d;
  logic [NCH-1:0]          ovf_set;
  logic [CHNBIT-1:0]       ptr_q, ptr_d;
  logic [CHNBIT-1:0]       oid_q, oid_d;
  logic [WID-1:0]          dout_q, dout_d;
  logic                    dovld_q, dovld_d;

  logic                    load_c;
  logic [NCH-1:0]          elig_c;
  logic                    found_c;
  logic                    gnt_c;
  logic [CHNBIT-1:0]       gnt_id_c;
  logic [SW-1:0]           sum_c;
  logic [CHNBIT-1:0]       idx_c;

  // Rotating first-eligible search starting one past the last grant.
  always_comb begin
    load_c   = !dovld_q || bus.dordy;
    elig_c   = pend_q & bus.chen;
    found_c  = 1'b0;
    gnt_id_c = '0;
    sum_c    = '0;
    idx_c    = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      sum_c = {1'b0, ptr_q} + SW'(i + 1);
      if (sum_c >= SW'(NCH)) begin
        sum_c = sum_c - SW'(NCH);
      end
      idx_c = sum_c[CHNBIT-1:0];
      if (!found_c && elig_c[idx_c]) begin
        found_c  = 1'b1;
        gnt_id_c = idx_c;
      end
    end
    gnt_c = load_c && found_c;
  end

  // Holding registers: a reload in the grant cycle is a hand-over, not an overflow.
  always_comb begin
    hold_d  = hold_q;
    pend_d  = pend_q;
    ovf_set = '0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (!bus.chen[k]) begin
        pend_d[k] = 1'b0;
      end else if (bus.vld[k]) begin
        hold_d[k] = bus.di[k*WID +: WID];
        pend_d[k] = 1'b1;
        if (pend_q[k] && !(gnt_c && (gnt_id_c == CHNBIT'(k)))) begin
          ovf_set[k] = 1'b1;
        end
      end else if (gnt_c && (gnt_id_c == CHNBIT'(k))) begin
        pend_d[k] = 1'b0;
      end
    end
    ovf_d = (bus.ovfclr ? '0 : ovf_q) | ovf_set;
  end

  // Output register; holds while stalled, drops valid when nothing is eligible.
  always_comb begin
    dout_d  = dout_q;
    oid_d   = oid_q;
    dovld_d = dovld_q;
    ptr_d   = ptr_q;
    if (load_c) begin
      if (found_c) begin
        dout_d  = hold_q[gnt_id_c];
        oid_d   = gnt_id_c;
        dovld_d = 1'b1;
        ptr_d   = gnt_id_c;
      end else begin
        dovld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      ptr_q   <= CHNBIT'(NCH - 1);
      oid_q   <= '0;
      dout_q  <= '0;
      dovld_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      oid_q   <= oid_d;
      dout_q  <= dout_d;
      dovld_q <= dovld_d;
    end
  end

  assign bus.oid   = oid_q;
  assign bus.dout  = dout_q;
  assign bus.dovld = dovld_q;
  assign bus.pend  = pend_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_e1_rr_sched.sv
// Scoreboard bench for e1_rr_sched: expected grants are queued as stimulus is
// applied and popped on every transfer seen on the output bus.
module tb_e1_rr_sched;

  localparam int unsigned WID    = 8;
  localparam int unsigned NCH    = 21;
  localparam int unsigned CHNBIT = 5;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [CHNBIT+WID-1:0] exp_q[$];

  e1_rr_sched_if #(.WID(WID), .NCH(NCH), .CHNBIT(CHNBIT)) bus ();

  e1_rr_sched #(.WID(WID), .NCH(NCH), .CHNBIT(CHNBIT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [WID-1:0] data);
    bus.vld[k]            = 1'b1;
    bus.di[k*WID +: WID]  = data;
  endtask

  task automatic clr_vld();
    bus.vld = '0;
  endtask

  task automatic exp_push(input int id, input logic [WID-1:0] data);
    exp_q.push_back({CHNBIT'(id), data});
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      step();
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    bus.vld    = '0;
    bus.ovfclr = 1'b0;
    exp_q.delete();
    step();
    step();
    rst        = 1'b1;
    bus.chen   = '1;
    bus.dordy  = 1'b1;
  endtask

  // Every transfer (dovld & dordy) must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && bus.dovld && bus.dordy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'({bus.oid, bus.dout}), 32'hFFFF_FFFF);
      end else begin
        check("grant", 32'({bus.oid, bus.dout}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b0;
    bus.di     = '0;
    bus.vld    = '0;
    bus.chen   = '1;
    bus.ovfclr = 1'b0;
    bus.dordy  = 1'b1;
    #3;
    check("rst_dovld", 32'(bus.dovld), 32'd0);
    check("rst_pend",  32'(bus.pend),  32'd0);
    check("rst_ovf",   32'(bus.ovf),   32'd0);
    check("rst_oid",   32'(bus.oid),   32'd0);
    check("rst_dout",  32'(bus.dout),  32'd0);

    // Single byte latency
    do_reset();
    exp_push(4, 8'hA5);
    set_ch(4, 8'hA5);
    step();
    clr_vld();
    check("t1_pend",   32'(bus.pend),  32'h10);
    check("t1_nvld",   32'(bus.dovld), 32'd0);
    step();
    check("t1_dovld",  32'(bus.dovld), 32'd1);
    check("t1_oid",    32'(bus.oid),   32'd4);
    check("t1_dout",   32'(bus.dout),  32'hA5);
    step();
    check("t1_pend0",  32'(bus.pend),  32'd0);
    check("t1_dovld0", 32'(bus.dovld), 32'd0);

    // All channels at once: 21 back-to-back grants in channel order
    do_reset();
    for (int k = 0; k < int'(NCH); k++) begin
      exp_push(k, WID'(k + 1));
      set_ch(k, WID'(k + 1));
    end
    step();
    clr_vld();
    step();
    for (int i = 0; i < int'(NCH); i++) begin
      check("t2_dovld", 32'(bus.dovld), 32'd1);
      check("t2_oid",   32'(bus.oid),   32'(i));
      step();
    end
    check("t2_dovld0", 32'(bus.dovld), 32'd0);
    check("t2_ovf",    32'(bus.ovf),   32'd0);
    check("t2_empty",  32'(exp_q.size()), 32'd0);

    // Two channels pending continuously alternate
    do_reset();
    exp_push(3, 8'h33); exp_push(17, 8'h71); exp_push(3, 8'h33);
    exp_push(17, 8'h71); exp_push(3, 8'h33);
    for (int c = 0; c < 4; c++) begin
      set_ch(3, 8'h33);
      set_ch(17, 8'h71);
      step();
    end
    clr_vld();
    drain(20);

    // Backpressure stall with overflow on the stalled channel
    do_reset();
    bus.dordy = 1'b0;
    exp_push(3, 8'h11); exp_push(5, 8'h55); exp_push(3, 8'h33);
    set_ch(3, 8'h11);
    set_ch(5, 8'h55);
    step();
    clr_vld();
    for (int s = 0; s < 5; s++) begin
      step();
      clr_vld();
      if (s == 0) set_ch(3, 8'h22);
      if (s == 1) set_ch(3, 8'h33);
      check("t4_stall_vld", 32'(bus.dovld), 32'd1);
      check("t4_stall_oid", 32'(bus.oid),   32'd3);
      check("t4_stall_do",  32'(bus.dout),  32'h11);
    end
    check("t4_ovf", 32'(bus.ovf), 32'h8);
    bus.dordy = 1'b1;
    drain(20);

    // Reload in the grant cycle is not an overflow
    do_reset();
    exp_push(9, 8'h91); exp_push(9, 8'h92);
    set_ch(9, 8'h91);
    step();
    set_ch(9, 8'h92);
    step();
    clr_vld();
    drain(10);
    check("t5_ovf", 32'(bus.ovf), 32'd0);

    // Disable flushes a pending channel; overflow wins over ovfclr
    do_reset();
    bus.dordy = 1'b0;
    exp_push(1, 8'h10); exp_push(2, 8'h22); exp_push(8, 8'h81);
    set_ch(1, 8'h10);
    set_ch(6, 8'h66);
    step();
    clr_vld();
    step();
    check("t6_pend6", 32'(bus.pend[6]), 32'd1);
    bus.chen[6] = 1'b0;
    set_ch(6, 8'h67);
    step();
    clr_vld();
    check("t6_flush", 32'(bus.pend), 32'd0);
    set_ch(2, 8'h20);
    set_ch(8, 8'h80);
    step();
    set_ch(2, 8'h21);
    set_ch(8, 8'h81);
    set_ch(6, 8'h68);
    step();
    clr_vld();
    set_ch(2, 8'h22);
    bus.ovfclr = 1'b1;
    step();
    bus.ovfclr = 1'b0;
    clr_vld();
    check("t6_ovf", 32'(bus.ovf), 32'h4);
    bus.dordy = 1'b1;
    drain(20);
    for (int s = 0; s < 5; s++) step();
    check("t6_pend_end", 32'(bus.pend), 32'd0);
    bus.chen[6] = 1'b1;

    // Reset mid-burst, then lowest pending channel wins first
    do_reset();
    for (int k = 0; k < int'(NCH); k++) begin
      exp_push(k, WID'(k + 1));
      set_ch(k, WID'(k + 1));
    end
    step();
    clr_vld();
    step();
    step();
    step();
    #1;
    rst = 1'b0;
    #1;
    check("t7_dovld", 32'(bus.dovld), 32'd0);
    check("t7_pend",  32'(bus.pend),  32'd0);
    check("t7_ovf",   32'(bus.ovf),   32'd0);
    check("t7_oid",   32'(bus.oid),   32'd0);
    check("t7_dout",  32'(bus.dout),  32'd0);
    exp_q.delete();
    step();
    rst = 1'b1;
    exp_push(7, 8'h70); exp_push(12, 8'hC1);
    set_ch(12, 8'hC1);
    set_ch(7, 8'h70);
    step();
    clr_vld();
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
